// File: rtl/ir_scan_scheduler.sv
// ir_scan_scheduler: sequences the eight QTR reflectance channels over two
// emitter banks (even LED: ch 0/2/4/6, odd LED: ch 1/3/5/7). Per bank the
// emitter is turned on and allowed to settle, the selected sensors are
// charged, then released while their decay times are counted in parallel.
// All results are published together as one frame with a valid pulse.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             request one scan (sampled only in IDLE)
//   continuous        re-arm a new scan automatically after every frame
//   channel_sel[7:0]  channel enables, latched at scan start
//   snsr_in[7:0]      raw sensor pad levels (asynchronous)
//   snsr_oe[7:0]      per-channel pad drive-high enable
//   ir_evenLED/ir_oddLED  emitter bank enables
//   busy              scan in progress
//   frame_valid       one-cycle pulse with each new frame
//   ttd               8 x TTD_W time-to-decay results, channel n at [n*TTD_W +: TTD_W]
//   timeout_flags     per-channel timeout indication for the last frame
//   frame_count       frames published since reset (wraps)
module ir_scan_scheduler #(
    parameter int unsigned CHARGE_CYCLES  = 160,
    parameter int unsigned SETTLE_CYCLES  = 3200,
    parameter int unsigned TIMEOUT_CYCLES = 32000,
    parameter int unsigned TTD_W          = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [7:0]           channel_sel,
    input  logic [7:0]           snsr_in,
    output logic [7:0]           snsr_oe,
    output logic                 ir_evenLED,
    output logic                 ir_oddLED,
    output logic                 busy,
    output logic                 frame_valid,
    output logic [8*TTD_W-1:0]   ttd,
    output logic [7:0]           timeout_flags,
    output logic [7:0]           frame_count
);

    localparam int unsigned N_CH    = 8;
    localparam int unsigned MAX_SC  = (SETTLE_CYCLES > CHARGE_CYCLES) ? SETTLE_CYCLES : CHARGE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SC > TIMEOUT_CYCLES) ? MAX_SC : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [N_CH-1:0] EVEN_MASK = 8'h55;
    localparam logic [N_CH-1:0] ODD_MASK  = 8'hAA;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CHARGE  = 3'd2,
        MEASURE = 3'd3,
        NEXT    = 3'd4,
        PUBLISH = 3'd5
    } state_e;

    state_e                         state_q, state_d;
    logic                           bank_q, bank_d;
    logic [N_CH-1:0]                sel_q, sel_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [N_CH-1:0]                done_q, done_d;
    logic [N_CH-1:0][TTD_W-1:0]     shad_q, shad_d;
    logic [N_CH-1:0]                sflag_q, sflag_d;
    logic [N_CH-1:0]                sync1_q, sync2_q;

    logic [N_CH-1:0]                oe_q, oe_d;
    logic                           even_led_q, even_led_d;
    logic                           odd_led_q, odd_led_d;
    logic                           busy_q, busy_d;
    logic                           fv_q, fv_d;
    logic [N_CH-1:0][TTD_W-1:0]     ttd_q, ttd_d;
    logic [N_CH-1:0]                flags_q, flags_d;
    logic [7:0]                     fcnt_q, fcnt_d;

    logic [N_CH-1:0]                act;
    logic [N_CH-1:0]                cap;
    logic                           led_on;

    function automatic logic [N_CH-1:0] bank_mask(input logic b);
        return b ? ODD_MASK : EVEN_MASK;
    endfunction

    // Next-state, measurement capture and registered-output computation
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q + CNT_W'(1);
        done_d     = done_q;
        shad_d     = shad_q;
        sflag_d    = sflag_q;
        ttd_d      = ttd_q;
        flags_d    = flags_q;
        fcnt_d     = fcnt_q;
        act        = sel_q & bank_mask(bank_q);
        cap        = '0;
        oe_d       = '0;
        even_led_d = 1'b0;
        odd_led_d  = 1'b0;
        busy_d     = 1'b0;
        fv_d       = 1'b0;
        led_on     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if ((start || continuous) && (channel_sel != '0)) begin
                    sel_d   = channel_sel;
                    bank_d  = 1'b0;
                    done_d  = '0;
                    shad_d  = '0;
                    sflag_d = '0;
                    // Even bank with nothing selected costs only the NEXT cycle
                    state_d = ((channel_sel & EVEN_MASK) != '0) ? SETTLE : NEXT;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = CHARGE;
            end
            CHARGE: begin
                if (cnt_q == CNT_W'(CHARGE_CYCLES - 1)) state_d = MEASURE;
            end
            MEASURE: begin
                cap = act & ~done_q & ~sync2_q;
                for (int i = 0; i < int'(N_CH); i++) begin
                    if (cap[i]) shad_d[i] = TTD_W'(cnt_q);
                end
                done_d = done_q | cap;
                if ((done_d & act) == act) begin
                    state_d = NEXT;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Captures in this cycle are already in done_d, so they win
                    for (int i = 0; i < int'(N_CH); i++) begin
                        if (act[i] && !done_d[i]) begin
                            shad_d[i]  = TTD_W'(TIMEOUT_CYCLES);
                            sflag_d[i] = 1'b1;
                        end
                    end
                    done_d  = done_d | act;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (!bank_q) begin
                    bank_d  = 1'b1;
                    state_d = ((sel_q & ODD_MASK) != '0) ? SETTLE : NEXT;
                end else begin
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                ttd_d   = shad_q;
                flags_d = sflag_q;
                fcnt_d  = fcnt_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Phase counter restarts on every state change
        if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;

        // Outputs are registered from the upcoming state so they align with it
        led_on     = (state_d == SETTLE) || (state_d == CHARGE) || (state_d == MEASURE);
        even_led_d = led_on && !bank_d;
        odd_led_d  = led_on && bank_d;
        oe_d       = (state_d == CHARGE) ? (sel_d & bank_mask(bank_d)) : '0;
        busy_d     = (state_d != IDLE);
        fv_d       = (state_q == PUBLISH);
    end

    // State, shadow and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bank_q     <= 1'b0;
            sel_q      <= '0;
            cnt_q      <= '0;
            done_q     <= '0;
            shad_q     <= '0;
            sflag_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            oe_q       <= '0;
            even_led_q <= 1'b0;
            odd_led_q  <= 1'b0;
            busy_q     <= 1'b0;
            fv_q       <= 1'b0;
            ttd_q      <= '0;
            flags_q    <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            shad_q     <= shad_d;
            sflag_q    <= sflag_d;
            sync1_q    <= snsr_in;
            sync2_q    <= sync1_q;
            oe_q       <= oe_d;
            even_led_q <= even_led_d;
            odd_led_q  <= odd_led_d;
            busy_q     <= busy_d;
            fv_q       <= fv_d;
            ttd_q      <= ttd_d;
            flags_q    <= flags_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign snsr_oe       = oe_q;
    assign ir_evenLED    = even_led_q;
    assign ir_oddLED     = odd_led_q;
    assign busy          = busy_q;
    assign frame_valid   = fv_q;
    assign ttd           = ttd_q;
    assign timeout_flags = flags_q;
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_ir_scan_scheduler.sv
// Testbench for ir_scan_scheduler: scoreboard of expected frames, popped on
// every frame_valid. Pad model: a driven pad reads 1, otherwise the line level.
module tb_ir_scan_scheduler;

    localparam int unsigned CHG   = 16;
    localparam int unsigned STL   = 40;
    localparam int unsigned TMO   = 500;
    localparam int unsigned TW    = 17;
    localparam int unsigned VW    = 8 * TW;
    localparam int          BOUND = 3 * int'(STL + CHG + TMO + 4);

    typedef struct {
        logic [VW-1:0] ttd;
        logic [7:0]    flags;
        logic [7:0]    fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          continuous;
    logic [7:0]    channel_sel;
    logic [7:0]    line;
    logic [7:0]    snsr_in;
    logic [7:0]    snsr_oe;
    logic          ir_evenLED;
    logic          ir_oddLED;
    logic          busy;
    logic          frame_valid;
    logic [VW-1:0] ttd;
    logic [7:0]    timeout_flags;
    logic [7:0]    frame_count;

    exp_t          sb_q[$];
    logic [7:0]    exp_fc;
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            oe0_cnt = 0, even_cnt = 0, odd_cnt = 0, overlap_cnt = 0;
    int            busy_cnt = 0, fv_cnt = 0, oe_bad = 0;
    int            fa [8];

    always #5 clk = ~clk;

    assign snsr_in = snsr_oe | line;

    ir_scan_scheduler #(
        .CHARGE_CYCLES  (CHG),
        .SETTLE_CYCLES  (STL),
        .TIMEOUT_CYCLES (TMO),
        .TTD_W          (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .continuous    (continuous),
        .channel_sel   (channel_sel),
        .snsr_in       (snsr_in),
        .snsr_oe       (snsr_oe),
        .ir_evenLED    (ir_evenLED),
        .ir_oddLED     (ir_oddLED),
        .busy          (busy),
        .frame_valid   (frame_valid),
        .ttd           (ttd),
        .timeout_flags (timeout_flags),
        .frame_count   (frame_count)
    );

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Activity monitors and scoreboard pop
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (snsr_oe[0]) oe0_cnt++;
            if (ir_evenLED) even_cnt++;
            if (ir_oddLED) odd_cnt++;
            if (ir_evenLED && ir_oddLED) overlap_cnt++;
            if (busy) busy_cnt++;
            if ((snsr_oe != 8'h00) && !((ir_evenLED && ((snsr_oe & 8'hAA) == 8'h00)) ||
                                        (ir_oddLED && ((snsr_oe & 8'h55) == 8'h00))))
                oe_bad++;
            if (frame_valid) begin
                fv_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", VW'(frame_count), VW'(exp_fc));
                    bad += (total > 0 && bad == 0) ? 0 : 0;
                end else begin
                    e = sb_q.pop_front();
                    chk("ttd", ttd, e.ttd);
                    chk("flags", VW'(timeout_flags), VW'(e.flags));
                    chk("frame_count", VW'(frame_count), VW'(e.fc));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; continuous = 1'b0; channel_sel = 8'h00; line = 8'hFF;
        tick(3);
        rst = 1'b0;
        sb_q.delete();
        exp_fc = 8'h00;
    endtask

    task automatic wait_oe(input logic [7:0] mask, input logic want_nz, input string tag);
        int t;
        t = 0;
        while ((((snsr_oe & mask) != 8'h00) != want_nz) && (t < BOUND)) begin
            @(negedge clk);
            t++;
        end
        chk(tag, VW'((snsr_oe & mask) != 8'h00), VW'(want_nz));
    endtask

    task automatic push_exp(input logic [7:0] sel, input int fall [8]);
        exp_t e;
        e.ttd   = '0;
        e.flags = '0;
        for (int n = 0; n < 8; n++) begin
            if (sel[n]) begin
                if ((fall[n] >= 0) && (fall[n] + 2 <= int'(TMO) - 1)) begin
                    e.ttd[n*TW +: TW] = TW'(fall[n] + 2);
                end else begin
                    e.ttd[n*TW +: TW] = TW'(TMO);
                    e.flags[n]        = 1'b1;
                end
            end
        end
        exp_fc = exp_fc + 8'd1;
        e.fc   = exp_fc;
        sb_q.push_back(e);
    endtask

    // One scan; fall[n] is the MEASURE cycle at which channel n's line drops (-1: never)
    task automatic run_scan(input logic [7:0] sel, input int fall [8], output int lat);
        int kmax;
        int c0;
        int t;
        logic [7:0] mask;
        push_exp(sel, fall);
        line = 8'hFF; channel_sel = sel; start = 1'b1; c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", VW'(busy), VW'(1));
        for (int b = 0; b < 2; b++) begin
            mask = (b == 0) ? 8'h55 : 8'hAA;
            if ((sel & mask) != 8'h00) begin
                wait_oe(mask, 1'b1, "oe_on");
                wait_oe(mask, 1'b0, "oe_off");
                kmax = -1;
                for (int n = 0; n < 8; n++)
                    if (sel[n] && mask[n] && (fall[n] > kmax) && (fall[n] < int'(TMO))) kmax = fall[n];
                for (int k = 0; k <= kmax; k++) begin
                    for (int n = 0; n < 8; n++)
                        if (sel[n] && mask[n] && (fall[n] == k)) line[n] = 1'b0;
                    @(negedge clk);
                end
            end
        end
        t = 0;
        while (!frame_valid && (t < BOUND)) begin
            @(negedge clk);
            t++;
        end
        chk("frame_valid", VW'(frame_valid), VW'(1));
        lat = cyc - c0;
        @(negedge clk);
        line = 8'hFF;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        int b_oe0, b_even, b_odd, b_fv, b_busy;
        int t;
        logic [7:0] sel_f;

        do_reset();
        chk("rst_oe", VW'(snsr_oe), VW'(0));
        chk("rst_even", VW'(ir_evenLED), VW'(0));
        chk("rst_odd", VW'(ir_oddLED), VW'(0));
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_fv", VW'(frame_valid), VW'(0));
        chk("rst_ttd", ttd, VW'(0));
        chk("rst_flags", VW'(timeout_flags), VW'(0));
        chk("rst_fc", VW'(frame_count), VW'(0));

        // Single channel 0, decay at cycle 100
        b_oe0 = oe0_cnt; b_even = even_cnt; b_odd = odd_cnt; b_fv = fv_cnt;
        fa = '{100, -1, -1, -1, -1, -1, -1, -1};
        run_scan(8'h01, fa, lat);
        tick(5);
        chk("t1_oe0_len", VW'(oe0_cnt - b_oe0), VW'(CHG));
        chk("t1_even_len", VW'(even_cnt - b_even), VW'(STL + CHG + 103));
        chk("t1_odd_led", VW'(odd_cnt - b_odd), VW'(0));
        chk("t1_fv_once", VW'(fv_cnt - b_fv), VW'(1));
        chk("t1_busy_fall", VW'(busy), VW'(0));

        // All channels, staggered decays
        fa = '{50, 100, 150, 200, 250, 300, 350, 400};
        run_scan(8'hFF, fa, lat);
        // Channel 7 never decays
        fa = '{50, 100, 150, 200, 250, 300, 350, -1};
        run_scan(8'hFF, fa, lat);
        // Timeout boundary: capture on the last count wins; one cycle later times out
        fa = '{int'(TMO) - 3, int'(TMO) - 2, -1, -1, -1, -1, -1, -1};
        run_scan(8'h03, fa, lat);

        // Even bank skipped
        b_even = even_cnt; b_odd = odd_cnt;
        fa = '{-1, 30, -1, -1, -1, -1, -1, -1};
        run_scan(8'h02, fa, lat);
        chk("t5_latency", VW'(lat), VW'(1 + 1 + STL + CHG + 33 + 1 + 1));
        chk("t5_even_led", VW'(even_cnt - b_even), VW'(0));
        chk("t5_odd_len", VW'(odd_cnt - b_odd), VW'(STL + CHG + 33));

        // Start with no channel selected
        b_busy = busy_cnt; b_fv = fv_cnt;
        channel_sel = 8'h00; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        chk("t6_busy_idle", VW'(busy_cnt - b_busy), VW'(0));
        chk("t6_no_frame", VW'(fv_cnt - b_fv), VW'(0));

        // Reset in the middle of MEASURE
        channel_sel = 8'h01; line = 8'hFF; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_oe(8'h01, 1'b1, "t7_oe_on");
        wait_oe(8'h01, 1'b0, "t7_oe_off");
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("t7_oe", VW'(snsr_oe), VW'(0));
        chk("t7_even", VW'(ir_evenLED), VW'(0));
        chk("t7_odd", VW'(ir_oddLED), VW'(0));
        chk("t7_busy", VW'(busy), VW'(0));
        chk("t7_fv", VW'(frame_valid), VW'(0));
        chk("t7_ttd", ttd, VW'(0));
        chk("t7_flags", VW'(timeout_flags), VW'(0));
        chk("t7_fc", VW'(frame_count), VW'(0));
        rst = 1'b0; sb_q.delete(); exp_fc = 8'h00;
        b_fv = fv_cnt; b_busy = busy_cnt;
        tick(int'(TMO) + 100);
        chk("t7_no_frame", VW'(fv_cnt - b_fv), VW'(0));
        chk("t7_stay_idle", VW'(busy_cnt - b_busy), VW'(0));

        // Continuous mode for 257 frames with a mid-scan selection change
        do_reset();
        b_fv = fv_cnt;
        channel_sel = 8'h01; line = 8'hFE;
        fa = '{-1, -1, -1, -1, -1, -1, -1, -1};
        continuous = 1'b1;
        for (int f = 0; f < 257; f++) begin
            sel_f = (f >= 152) ? 8'h03 : 8'h01;
            // Line held low: decay seen two cycles into MEASURE
            fa[0] = 0;
            fa[1] = 0;
            push_exp(sel_f, fa);
            t = 0;
            while (!frame_valid && (t < BOUND)) begin
                @(negedge clk);
                t++;
            end
            chk("cont_fv", VW'(frame_valid), VW'(1));
            if (f == 256) continuous = 1'b0;
            if (f == 150) begin
                tick(5);
                channel_sel = 8'h03;
                line = 8'hFC;
            end else begin
                tick(1);
            end
        end
        tick(int'(STL + CHG) + 100);
        chk("cont_fc_wrap", VW'(frame_count), VW'(1));
        chk("cont_frames", VW'(fv_cnt - b_fv), VW'(257));

        chk("led_overlap", VW'(overlap_cnt), VW'(0));
        chk("oe_outside_charge", VW'(oe_bad), VW'(0));
        chk("sb_drained", VW'(sb_q.size()), VW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_scan_scheduler.md
# ir_scan_scheduler

Sequences the eight QTR reflectance channels and their two emitter banks (even LED: channels 0/2/4/6; odd LED: 1/3/5/7). For each bank, one scan turns on the emitter, lets it settle, charges the selected sensors, releases them and times each decay in parallel. A timeout bounds each measurement. All channel results are published together as one coherent frame with a valid pulse. It sits between the top-level sensor pads (the top instantiates the tristate buffers) and the robot control logic that consumes time-to-decay values.

## Interface
- CHARGE_CYCLES, 160: sensor drive-high time (10 µs at 16 MHz).
- SETTLE_CYCLES, 3200: emitter-on delay before charging (200 µs).
- TIMEOUT_CYCLES, 32000: maximum decay count (2 ms); must be < 2^TTD_W.
- TTD_W, 17: width of each time-to-decay result.
- clk  in  1  system clock (WF_CLK, 16 MHz); one clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one scan; sampled only in IDLE.
- continuous  in  1  while high, a new scan starts automatically after each PUBLISH.
- channel_sel  in  8  channel enables; latched at scan start.
- snsr_in  in  8  raw sensor pad levels (asynchronous).
- snsr_oe  out  8  per-channel drive-high enable; the pad drives 1 when set, Z otherwise.
- ir_evenLED, ir_oddLED  out  1 each  emitter bank enables.
- busy  out  1  high from scan start through PUBLISH.
- frame_valid  out  1  one-cycle pulse when a new frame is on the outputs.
- ttd  out  8*TTD_W  channel n at bits [n*TTD_W +: TTD_W].
- timeout_flags  out  8  bit n set if channel n hit the timeout in the last frame.
- frame_count  out  8  frames published since reset; wraps from 255 to 0.

## Operation
- snsr_in passes through a 2-flop synchronizer per bit. All decay detection uses the synchronized value.
- State machine: IDLE, SETTLE, CHARGE, MEASURE, NEXT, PUBLISH. A bank register selects even (0) or odd (1).
- IDLE
  - Leaves IDLE on (start | continuous) with channel_sel != 0.
  - On that exit: latch sel_q = channel_sel, set bank = 0, clear shadow results and done bits, go to SETTLE.
  - With channel_sel == 0, stays in IDLE and start is dropped.
- Bank skip: on entry to any bank, if that bank has no selected channel, go directly to NEXT. No LED and no oe activity occur for a skipped bank.
- SETTLE: the current bank's LED is on; count SETTLE_CYCLES, then go to CHARGE.
- CHARGE: LED stays on; snsr_oe = sel_q & bank_mask; count CHARGE_CYCLES, then go to MEASURE.
- MEASURE
  - LED stays on; snsr_oe = 0; the measure counter starts at 0 on the first MEASURE cycle and increments every cycle.
  - For each active channel not yet done: when its synchronized input is 0, capture the counter into its shadow result and set done.
  - Exit to NEXT when every active channel is done, or when counter == TIMEOUT_CYCLES-1.
  - On timeout, each undone channel gets the value TIMEOUT_CYCLES and its timeout flag set.
  - A capture and the timeout occurring in the same cycle: the capture wins.
- NEXT: both LEDs off. If bank == 0, set bank = 1 and apply the bank-skip rule for the odd bank. If bank == 1, go to PUBLISH.
- PUBLISH
  - Copy shadow results to ttd and timeout_flags. Unselected channels read 0 with flag 0.
  - Pulse frame_valid; increment frame_count.
  - Go to IDLE. If continuous is high, the next scan starts on the following cycle.
- Outputs hold between frames. channel_sel changes and start pulses during a scan are ignored.
- Only one LED is ever on at a time. snsr_oe is never set outside CHARGE.

## Timing
- Reset values: snsr_oe = 0, both LEDs 0, busy 0, frame_valid 0, ttd all 0, timeout_flags 0, frame_count 0, state IDLE, synchronizer flops 0.
- rst takes effect at the next clock edge from any state; a scan in progress is abandoned with no frame published.
- busy rises the cycle after start is sampled and falls the cycle after PUBLISH.
- Per active bank: SETTLE_CYCLES + CHARGE_CYCLES + M measure cycles + 1 NEXT cycle, where M ≤ TIMEOUT_CYCLES.
- PUBLISH adds 1 cycle; a skipped bank costs exactly 1 cycle.
- Decay value: if snsr_in falls before the clock edge of MEASURE cycle k and stays low, ttd = k + 2 (2-cycle synchronizer latency).
- frame_valid is asserted in the same cycle the new ttd and flags are first visible.

## Test plan
- Reset, then start with channel_sel = 8'h01 and snsr_in[0] falling at MEASURE cycle 100 → oe[0] high for exactly 160 cycles, even LED on, odd LED never on, ttd[0] = 102, flags = 0, frame_count = 1, single frame_valid.
- channel_sel = 8'hFF with channel n falling at cycle 50·(n+1) → ttd[n] = 50(n+1) + 2 and LEDs never overlap. Hold snsr_in[7] high instead → ttd[7] = 32000 and flags = 8'h80.
- channel_sel = 8'h02 → even bank skipped: ir_evenLED never asserts, odd bank runs; start-to-frame_valid latency = 1 + 1 + 3200 + 160 + M + 1 + 1 cycles.
- continuous = 1 for 257 frames → frame_count wraps to 1. A channel_sel change mid-scan takes effect only in the next frame.
- rst asserted during MEASURE → next cycle all outputs are at reset values and no frame_valid pulse occurs. A start issued with channel_sel = 0 → busy stays 0.
